// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - divides clk into a 50% duty square wave with a toggle strobe and live count
module clk_divider #(
    parameter int COUNTER_NUM = 100000,
    parameter int CNT_W       = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             invert,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    generate
        if (COUNTER_NUM < 1) begin : g_bad_counter_num
            $error("clk_divider: COUNTER_NUM must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNTER_NUM - 1);

    // The wrap edge both toggles invert and raises tick, so tick marks every
    // invert transition and the count never passes LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            invert <= 1'b0;
            tick   <= 1'b0;
        end else if (count == LAST) begin
            count  <= '0;
            invert <= ~invert;
            tick   <= 1'b1;
        end else begin
            count  <= count + CNT_W'(1);
            tick   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider at several divide ratios
module tb_clk_divider;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic        inv4, tick4, inv1, tick1, inv5, tick5, inv12, tick12;
    logic [1:0]  cnt4;
    logic        cnt1;
    logic [2:0]  cnt5;
    logic [10:0] cnt12;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   id;
        int   k;
        int   cnt;
        logic inv;
        logic tck;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clk_divider #(.COUNTER_NUM(4)) u_div4 (
        .clk(clk), .rst(rst_a), .invert(inv4), .tick(tick4), .count(cnt4)
    );
    clk_divider #(.COUNTER_NUM(1)) u_div1 (
        .clk(clk), .rst(rst_a), .invert(inv1), .tick(tick1), .count(cnt1)
    );
    clk_divider #(.COUNTER_NUM(5)) u_div5 (
        .clk(clk), .rst(rst_b), .invert(inv5), .tick(tick5), .count(cnt5)
    );
    clk_divider #(.COUNTER_NUM(1200)) u_div1200 (
        .clk(clk), .rst(rst_a), .invert(inv12), .tick(tick12), .count(cnt12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected state after the k-th edge following reset release.
    function automatic exp_t model(input int id, input int n, input int k);
        exp_t e;
        e.id  = id;
        e.k   = k;
        e.cnt = k % n;
        e.inv = ((k / n) % 2) == 1;
        e.tck = (k >= 1) && ((k % n) == 0);
        return e;
    endfunction

    task automatic get_outputs(input int id, output logic [31:0] c, output logic i, output logic t);
        case (id)
            0:       begin c = 32'(cnt4);  i = inv4;  t = tick4;  end
            1:       begin c = 32'(cnt1);  i = inv1;  t = tick1;  end
            2:       begin c = 32'(cnt5);  i = inv5;  t = tick5;  end
            default: begin c = 32'(cnt12); i = inv12; t = tick12; end
        endcase
    endtask

    task automatic drain_scoreboard();
        exp_t        e;
        logic [31:0] c;
        logic        i, t;
        string       nm;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_outputs(e.id, c, i, t);
            nm = $sformatf("div%0d k=%0d", e.id, e.k);
            check({nm, " count"}, c, 32'(e.cnt));
            check({nm, " invert"}, 32'(i), 32'(e.inv));
            check({nm, " tick"}, 32'(t), 32'(e.tck));
        end
    endtask

    task automatic check_reset_state(input string tag, input int id);
        logic [31:0] c;
        logic        i, t;
        get_outputs(id, c, i, t);
        check({tag, " count"}, c, 32'd0);
        check({tag, " invert"}, 32'(i), 32'd0);
        check({tag, " tick"}, 32'(t), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) check_reset_state($sformatf("reset div%0d", id), id);

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            sb.push_back(model(0, 4, k));
            sb.push_back(model(1, 1, k));
            sb.push_back(model(2, 5, k));
            sb.push_back(model(3, 1200, k));
            @(posedge clk);
            #1;
            drain_scoreboard();
        end

        // Restart div5, run to count=3 with invert=1, then reset between edges.
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("sync-held reset div5", 2);
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            sb.push_back(model(2, 5, k));
            @(posedge clk);
            #1;
            drain_scoreboard();
        end
        #1;
        rst_b = 1'b1;
        #1;
        check_reset_state("async reset div5", 2);
        @(posedge clk);
        #1;
        check_reset_state("reset held over edge div5", 2);
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            sb.push_back(model(2, 5, k));
            @(posedge clk);
            #1;
            drain_scoreboard();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
